// File: rtl/icache_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : icache_controller_if
// Description : Bundles the fetch-side (CPU/selector) and fill-side
//               (instruction memory) signals of the instruction cache
//               controller.
//   address        fetch byte address {tag[9:7], index[6:4], word[3:2], --}
//   busywait       CPU stall request (high = fetch not yet served)
//   block_word1..4 words 0..3 of the addressed line
//   word_select    address[3:2], select for the downstream word selector
//   mem_read       block read request to instruction memory
//   mem_address    block address {tag,index} of the line being filled
//   mem_readdata   128-bit fill data, valid when mem_busywait is low
//   mem_busywait   memory busy while the requested data is not ready
//   slave modport  : the cache controller's view
//   master modport : the CPU + memory environment's view
// Revision    : 1.0 - initial release
// ============================================================================
interface icache_controller_if;
  logic [9:0]   address;
  logic         busywait;
  logic [31:0]  block_word1;
  logic [31:0]  block_word2;
  logic [31:0]  block_word3;
  logic [31:0]  block_word4;
  logic [1:0]   word_select;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport slave (
    input  address, mem_readdata, mem_busywait,
    output busywait, block_word1, block_word2, block_word3, block_word4,
           word_select, mem_read, mem_address
  );

  modport master (
    output address, mem_readdata, mem_busywait,
    input  busywait, block_word1, block_word2, block_word3, block_word4,
           word_select, mem_read, mem_address
  );
endinterface
`default_nettype wire

// File: rtl/icache_controller.sv
`default_nettype none
// ============================================================================
// Module      : icache_controller
// Description : Direct-mapped instruction cache controller, 8 lines of
//               16 bytes, 10-bit byte address. Hits are served with zero
//               added latency; misses stall the CPU and fill the line from
//               128-bit-wide instruction memory.
// Ports       : CLK   - single clock, rising edge
//               RESET - synchronous active-high reset
//               bus   - icache_controller_if.slave (fetch + fill signals)
// Revision    : 1.0 - initial release
// ============================================================================
module icache_controller (
  input  wire logic          CLK,
  input  wire logic          RESET,
  icache_controller_if.slave bus
);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_MEM_READ = 1'b1;

  logic [0:0]   r_state;
  logic [2:0]   r_fill_tag;
  logic [2:0]   r_fill_index;
  logic [7:0]   r_valid;
  logic [2:0]   r_tag  [0:7];
  logic [127:0] r_data [0:7];

  logic [2:0]   w_tag;
  logic [2:0]   w_index;
  logic         w_hit;
  logic         w_fill_done;
  logic [127:0] w_line;
  logic [1:0]   w_unused_addr_lsb;

  assign w_tag             = bus.address[9:7];
  assign w_index           = bus.address[6:4];
  assign w_unused_addr_lsb = bus.address[1:0];

  // Hit is evaluated on the live address so a hit costs no extra cycle.
  assign w_hit = r_valid[w_index] && (r_tag[w_index] == w_tag);

  // A reset coinciding with the data-ready cycle must not commit the fill.
  assign w_fill_done = (r_state == S_MEM_READ) && !bus.mem_busywait && !RESET;

  assign w_line          = r_data[w_index];
  assign bus.block_word1 = w_line[31:0];
  assign bus.block_word2 = w_line[63:32];
  assign bus.block_word3 = w_line[95:64];
  assign bus.block_word4 = w_line[127:96];
  assign bus.word_select = bus.address[3:2];

  assign bus.busywait    = (r_state == S_IDLE) ? !w_hit : 1'b1;
  assign bus.mem_read    = (r_state == S_MEM_READ);
  assign bus.mem_address = (r_state == S_MEM_READ) ? {r_fill_tag, r_fill_index} : 6'd0;

  // Control state and valid bits.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_fill_tag   <= '0;
      r_fill_index <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_hit) begin
            // Latch the line to fill; later address changes do not redirect it.
            r_fill_tag   <= w_tag;
            r_fill_index <= w_index;
            r_state      <= S_MEM_READ;
          end
        end
        S_MEM_READ: begin
          if (!bus.mem_busywait) begin
            r_valid[r_fill_index] <= 1'b1;
            r_state               <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (w_fill_done) begin
      r_data[r_fill_index] <= bus.mem_readdata;
      r_tag[r_fill_index]  <= r_fill_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_controller
// Description : Self-checking bench for icache_controller. Directed cycles
//               push the expected outputs into a queue; a monitor on the
//               falling edge pops and compares against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_controller;

  logic clk;
  logic rst;

  icache_controller_if bus ();

  icache_controller dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic         bw;
    logic         mr;
    logic [5:0]   ma;
    logic [1:0]   ws;
    logic         chkw;
    logic [127:0] words;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Memory block contents: word w of block ba is {16'hC0DE, 8'h00, ba, w}.
  function automatic logic [127:0] blk(input logic [5:0] ba);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[w*32 +: 32] = {16'hC0DE, 8'h00, ba, w[1:0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the scoreboard queue.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check({e.name, ".busywait"},    {127'd0, bus.busywait},    {127'd0, e.bw});
      check({e.name, ".mem_read"},    {127'd0, bus.mem_read},    {127'd0, e.mr});
      check({e.name, ".mem_address"}, {122'd0, bus.mem_address}, {122'd0, e.ma});
      check({e.name, ".word_select"}, {126'd0, bus.word_select}, {126'd0, e.ws});
      if (e.chkw)
        check({e.name, ".block_words"},
              {bus.block_word4, bus.block_word3, bus.block_word2, bus.block_word1}, e.words);
    end
  end

  // One cycle of stimulus, with its expected outputs queued when chk is set.
  task automatic cyc(input string name, input logic [9:0] a, input logic r, input logic mbw,
                     input logic chk, input logic e_bw, input logic e_mr,
                     input logic [5:0] e_ma, input logic chkw);
    exp_t e;
    @(posedge clk);
    #1;
    bus.address      = a;
    rst              = r;
    bus.mem_busywait = mbw;
    bus.mem_readdata = mbw ? {4{32'hDEAD_BEEF}} : blk(e_ma);
    if (chk) begin
      e.name  = name;
      e.bw    = e_bw;
      e.mr    = e_mr;
      e.ma    = e_ma;
      e.ws    = a[3:2];
      e.chkw  = chkw;
      e.words = blk(a[9:4]);
      q.push_back(e);
    end
  endtask

  task automatic hit(input string name, input logic [9:0] a);
    cyc(name, a, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1);
  endtask

  // Idle miss cycle then k MEM_READ cycles, memory ready in the k-th.
  task automatic miss_fill(input string name, input logic [9:0] a, input int k);
    cyc(name, a, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);
    for (int i = 1; i <= k; i++)
      cyc(name, a, 1'b0, (i != k), 1'b1, 1'b1, 1'b1, a[9:4], 1'b0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.address      = 10'h000;
    bus.mem_busywait = 1'b1;
    bus.mem_readdata = '0;

    // Reset state.
    cyc("reset0", 10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0);
    cyc("reset",  10'h000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0);

    // Cold miss with latency 5, then sequential hits across the line.
    miss_fill("fill0_k5", 10'h000, 5);
    hit("seq0", 10'h000);
    hit("seq1", 10'h004);
    hit("seq2", 10'h008);
    hit("seq3", 10'h00C);

    // Conflict on index 1.
    miss_fill("fill010", 10'h010, 2);
    hit("hit010", 10'h010);
    miss_fill("fill090", 10'h090, 3);
    hit("hit090", 10'h094);
    miss_fill("refill010", 10'h010, 2);
    hit("rehit010", 10'h01C);

    // Address changes in the 2nd MEM_READ cycle; fill completes for the old line.
    cyc("chg_idle", 10'h020, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0);
    cyc("chg_mr1",  10'h020, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h02, 1'b0);
    cyc("chg_mr2",  10'h3F0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h02, 1'b0);
    cyc("chg_mr3",  10'h3F0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h02, 1'b0);
    miss_fill("fill3F0", 10'h3F0, 1);
    hit("hit3F0", 10'h3F8);
    hit("hit020", 10'h024);

    // Reset in the 3rd MEM_READ cycle with data arriving in that same cycle.
    cyc("rst_idle", 10'h050, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'h00, 1'b0);
    cyc("rst_mr1",  10'h050, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h05, 1'b0);
    cyc("rst_mr2",  10'h050, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'h05, 1'b0);
    cyc("rst_mr3",  10'h050, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 6'h05, 1'b0);
    miss_fill("after_rst020", 10'h020, 1);
    hit("hit020b", 10'h020);
    miss_fill("after_rst050", 10'h050, 1);
    hit("hit050", 10'h05C);

    // Minimum latency k=1: two stall cycles, then hit.
    miss_fill("k1", 10'h100, 1);
    hit("k1_hit", 10'h108);

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
